display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares the board display (LEDR, HEX0–HEX5) between up to NUM_SRC design blocks.
- Replaces static switch-select muxing with a sequenced arbiter:
  - manual round-robin advance on a debounced KEY press;
  - optional timed auto-rotation;
  - a blanking gap on every source change, so the display never tears between sources.
- Sits between the design instances and the board pins in top-level integration.

Parameters:
- NUM_SRC, 2, number of requesting display sources (2..4).
- DEBOUNCE_CYCLES, 500000, cycles the synchronized KEY must stay stable before a level change is accepted (10 ms at 50 MHz).
- DWELL_CYCLES, 100000000, cycles a source is shown before an auto-rotate advance (2 s).
- BLANK_CYCLES, 5000000, cycles of blanked display between sources (100 ms).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous and active-low.
- src_frame  in  58*NUM_SRC  per-source frame at [58*i +: 58].
  - Frame layout: [9:0]=LEDR, [17:10]=HEX0, [25:18]=HEX1, [33:26]=HEX2, [41:34]=HEX3, [49:42]=HEX4, [57:50]=HEX5.
- src_req  in  NUM_SRC  source i has valid content to show.
- key_next_n  in  1  raw asynchronous push-button, low = pressed.
- auto_en  in  1  level; 1 = auto-rotate enabled.
- LEDR  out  10  registered LED drive.
- HEX0..HEX5  out  8 each  registered segment drive, active-low; blank = 8'hFF.
- sel  out  clog2(NUM_SRC) (min 1)  index of the source currently owning the display.
- switch_pulse  out  1  one-cycle strobe when sel changes.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, sel=0, LEDR=0, all HEX=8'hFF, switch_pulse=0;
  - debounce stable level=1 (released), dwell and blank counters=0.
  - Reset applies in any state, including mid-BLANK and mid-debounce.
- Key path: 2-FF synchronizer, then debounce.
  - The counter restarts on every change of the synchronized level.
  - The stable level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - press_evt = one-cycle pulse on a stable 1->0 transition.
- Next-source search: the first requesting index starting at sel+1, wrapping modulo NUM_SRC; sel itself is checked last.
- States:
  - IDLE: outputs blank.
    - If any src_req bit is set, search from sel inclusive, load sel, go to SHOW.
    - No blank gap; switch_pulse only if sel changed.
  - SHOW: each cycle, outputs <= src_frame[sel] (1-cycle latency, live).
    - Dwell counter increments while auto_en=1; it is held at 0 while auto_en=0.
    - Trigger = press_evt, OR (auto_en && dwell==DWELL_CYCLES-1), OR src_req[sel]==0.
    - On trigger with another requester available: go to BLANK, dwell=0.
    - On trigger where only sel requests: stay in SHOW, dwell=0, no blank, no pulse.
    - On trigger with no requester: go to IDLE.
    - Simultaneous press and expiry = one advance only.
  - BLANK: outputs blank (LEDR=0, HEX=FF) starting the cycle after the trigger. Runs for BLANK_CYCLES cycles.
    - press_evt is discarded.
    - At the end, search again from the current sel. If found: load sel, go to SHOW, switch_pulse=1 for that cycle. If none: go to IDLE.
    - A target that drops its request during BLANK is therefore skipped.
- All counters are sized with $clog2 of their parameter and saturate at their terminal value; none wrap.
- Source content is never inspected or modified.

Decomposition:
- Shared package display_pkg:
  - FRAME_W=58 and the LEDR/HEX field offsets;
  - HEX_BLANK=8'hFF, LED_OFF=10'h0;
  - arbiter state enum {IDLE, SHOW, BLANK}.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset_n, key_n, stable, press_evt). Reusable for other KEY inputs.
- The arbiter FSM, search logic and output register stay in display_arbiter.

Test Plan:
(Common setup: NUM_SRC=2, DEBOUNCE_CYCLES=4, DWELL_CYCLES=16, BLANK_CYCLES=3; frame0 LEDR=10'h155, frame1 LEDR=10'h2AA.)
1. Reset: reset_n=0 for 3 cycles with src_req=2'b00 -> LEDR=0, HEX0..5=FF, sel=0. Then src_req=2'b11 -> next cycle SHOW with sel=0; one cycle later LEDR=10'h155.
2. Debounce and manual advance:
   - key_next_n low for 2 cycles -> no change.
   - key_next_n low for 8 cycles -> press_evt, then 3 blank cycles (LEDR=0), then sel=1 with switch_pulse high for 1 cycle; LEDR=10'h2AA one cycle later.
3. Auto-rotate:
   - auto_en=1, src_req=2'b11 -> sel alternates 0,1,0 with a period of 16 SHOW + 3 BLANK cycles.
   - press_evt coincident with dwell expiry -> exactly one advance.
4. Request drop and single requester:
   - sel=1 showing, src_req=2'b01 -> BLANK, then sel=0.
   - Then src_req=2'b00 -> IDLE, blank outputs.
   - src_req=2'b10 with a key press -> sel stays 1, no blank, no switch_pulse.
5. Reset mid-BLANK: assert reset_n=0 during BLANK cycle 2 -> next edge IDLE, sel=0, outputs blank, switch_pulse=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the board display arbiter.
// One display frame packs LEDR and HEX0..HEX5 for a single source.
package display_pkg;

  localparam int unsigned FRAME_W  = 58;
  localparam int unsigned LEDR_W   = 10;
  localparam int unsigned HEX_W    = 8;
  localparam int unsigned LEDR_LSB = 0;
  localparam int unsigned HEX0_LSB = 10;
  localparam int unsigned HEX1_LSB = 18;
  localparam int unsigned HEX2_LSB = 26;
  localparam int unsigned HEX3_LSB = 34;
  localparam int unsigned HEX4_LSB = 42;
  localparam int unsigned HEX5_LSB = 50;

  localparam logic [HEX_W-1:0]  HEX_BLANK = 8'hFF;
  localparam logic [LEDR_W-1:0] LED_OFF   = 10'h0;

  // Field order matches the bit layout: ledr in [9:0], hex5 in [57:50].
  typedef struct packed {
    logic [HEX_W-1:0]  hex5;
    logic [HEX_W-1:0]  hex4;
    logic [HEX_W-1:0]  hex3;
    logic [HEX_W-1:0]  hex2;
    logic [HEX_W-1:0]  hex1;
    logic [HEX_W-1:0]  hex0;
    logic [LEDR_W-1:0] ledr;
  } frame_t;

  localparam frame_t BLANK_FRAME = frame_t'({{6{HEX_BLANK}}, LED_OFF});

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } arb_state_e;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability debounce and a
// one-cycle press event on an accepted released->pressed transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic stable,
  output logic press_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      prev_q    <= 1'b1;
      cnt_q     <= '0;
      stable    <= 1'b1;
      press_evt <= 1'b0;
    end else begin
      meta_q    <= key_n;
      sync_q    <= meta_q;
      prev_q    <= sync_q;
      press_evt <= 1'b0;
      // Any change of the synchronized level restarts the stability window.
      if (sync_q != prev_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        stable    <= sync_q;
        press_evt <= stable & ~sync_q;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Sequenced owner of the board display: round-robin on key press or dwell
// timeout, with a blanking gap between sources so frames never tear.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DWELL_CYCLES    = 100000000,
  parameter int unsigned BLANK_CYCLES    = 5000000,
  localparam int unsigned SEL_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [FRAME_W*NUM_SRC-1:0] src_frame,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic                       key_next_n,
  input  logic                       auto_en,
  output logic [LEDR_W-1:0]          LEDR,
  output logic [HEX_W-1:0]           HEX0,
  output logic [HEX_W-1:0]           HEX1,
  output logic [HEX_W-1:0]           HEX2,
  output logic [HEX_W-1:0]           HEX3,
  output logic [HEX_W-1:0]           HEX4,
  output logic [HEX_W-1:0]           HEX5,
  output logic [SEL_W-1:0]           sel,
  output logic                       switch_pulse
);

  localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLANK_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [BL_W-1:0]  blank_q, blank_d;
  logic             pulse_q, pulse_d;
  frame_t           disp_q, disp_d;

  logic             press_evt;
  logic             key_stable;
  frame_t           frames [NUM_SRC];
  logic [NUM_SRC-1:0] req_sh;
  logic             trigger;
  logic             cur_found, nxt_found;
  logic [SEL_W-1:0] cur_idx, nxt_idx;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_n     (key_next_n),
    .stable    (key_stable),
    .press_evt (press_evt)
  );

  a_press_follows_stable: assert property (
    @(posedge clk) disable iff (!reset_n) press_evt |-> !key_stable);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_frame
    assign frames[g] = src_frame[FRAME_W*g +: FRAME_W];
  end

  // First requester at or after start, wrapping; returns {found, index}.
  function automatic logic [SEL_W:0] search(input logic [NUM_SRC-1:0] req,
                                            input int unsigned start);
    logic [SEL_W:0]     res;
    logic [NUM_SRC-1:0] sh;
    int unsigned        idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (start + k) % NUM_SRC;
      sh  = req >> idx;
      if (!res[SEL_W] && sh[0]) res = {1'b1, SEL_W'(idx)};
    end
    return res;
  endfunction

  assign {cur_found, cur_idx} = search(src_req, 32'(sel_q));
  assign {nxt_found, nxt_idx} = search(src_req, 32'(sel_q) + 32'd1);
  assign req_sh  = src_req >> sel_q;
  assign trigger = press_evt || (auto_en && (dwell_q == DW_MAX)) || !req_sh[0];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = '0;
    blank_d = '0;
    pulse_d = 1'b0;
    disp_d  = BLANK_FRAME;
    case (state_q)
      IDLE: begin
        if (cur_found) begin
          state_d = SHOW;
          sel_d   = cur_idx;
          pulse_d = (cur_idx != sel_q);
        end
      end
      SHOW: begin
        if (!trigger) begin
          disp_d = frames[sel_q];
          if (auto_en) dwell_d = (dwell_q == DW_MAX) ? dwell_q : dwell_q + DW_W'(1);
        end else if (nxt_found && (nxt_idx != sel_q)) begin
          state_d = BLANK;
        end else if (nxt_found) begin
          disp_d = frames[sel_q];
        end else begin
          state_d = IDLE;
        end
      end
      BLANK: begin
        if (blank_q != BL_MAX) begin
          blank_d = blank_q + BL_W'(1);
        end else if (nxt_found) begin
          state_d = SHOW;
          sel_d   = nxt_idx;
          pulse_d = (nxt_idx != sel_q);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dwell_q <= '0;
      blank_q <= '0;
      pulse_q <= 1'b0;
      disp_q  <= BLANK_FRAME;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
      disp_q  <= disp_d;
    end
  end

  assign LEDR         = disp_q.ledr;
  assign HEX0         = disp_q.hex0;
  assign HEX1         = disp_q.hex1;
  assign HEX2         = disp_q.hex2;
  assign HEX3         = disp_q.hex3;
  assign HEX4         = disp_q.hex4;
  assign HEX5         = disp_q.hex5;
  assign sel          = sel_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: a reference model predicts every
// cycle's display, selection and switch strobe; a monitor pops and compares.
module tb_display_arbiter;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned DEB     = 4;
  localparam int unsigned DWELL   = 16;
  localparam int unsigned BLANK   = 3;
  localparam int unsigned SEL_W   = 1;
  localparam int unsigned FW      = 58;

  logic                  clk;
  logic                  reset_n;
  logic [FW*NUM_SRC-1:0] src_frame;
  logic [NUM_SRC-1:0]    src_req;
  logic                  key_next_n;
  logic                  auto_en;
  logic [9:0]            LEDR;
  logic [7:0]            HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [SEL_W-1:0]      sel;
  logic                  switch_pulse;

  display_arbiter #(
    .NUM_SRC         (NUM_SRC),
    .DEBOUNCE_CYCLES (DEB),
    .DWELL_CYCLES    (DWELL),
    .BLANK_CYCLES    (BLANK)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_frame    (src_frame),
    .src_req      (src_req),
    .key_next_n   (key_next_n),
    .auto_en      (auto_en),
    .LEDR         (LEDR),
    .HEX0         (HEX0),
    .HEX1         (HEX1),
    .HEX2         (HEX2),
    .HEX3         (HEX3),
    .HEX4         (HEX4),
    .HEX5         (HEX5),
    .sel          (sel),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  ledr;
    logic [47:0] hex;
    int          sel;
    bit          pulse;
  } exp_t;

  exp_t exp_q[$];
  int   sw_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: 0 = idle, 1 = showing, 2 = blanking gap.
  int m_phase = 0;
  int m_sel = 0;
  int m_dwell = 0;
  int m_blank_left = 0;
  bit m_press = 0;
  bit m_stable = 1;
  bit key_hist[$];

  function automatic int first_from(input bit [NUM_SRC-1:0] r, input int start);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r[(start + k) % NUM_SRC]) return (start + k) % NUM_SRC;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit press_now, trig, others, show, same;
    bit [NUM_SRC-1:0] req;
    int nsel;
    e.ledr = 10'h0; e.hex = '1; e.pulse = 1'b0; show = 1'b0;
    if (!reset_n) begin
      m_phase = 0; m_sel = 0; m_dwell = 0; m_blank_left = 0;
      m_press = 0; m_stable = 1;
      key_hist.delete();
      for (int i = 0; i < DEB + 3; i++) key_hist.push_front(1'b1);
    end else begin
      press_now = m_press;
      req = src_req;
      // Key accepted once the synchronized level (2 cycles late) held for DEB+1 samples.
      key_hist.push_front(key_next_n);
      while (key_hist.size() > DEB + 3) void'(key_hist.pop_back());
      same = 1'b1;
      for (int j = 3; j <= DEB + 2; j++) if (key_hist[j] != key_hist[2]) same = 1'b0;
      m_press = 1'b0;
      if (same) begin
        m_press  = m_stable && !key_hist[2];
        m_stable = key_hist[2];
      end
      case (m_phase)
        0: begin
          nsel = first_from(req, m_sel);
          if (nsel >= 0) begin
            e.pulse = (nsel != m_sel);
            m_sel = nsel; m_phase = 1; m_dwell = 0;
          end
        end
        1: begin
          trig = press_now || (auto_en && m_dwell == DWELL - 1) || !req[m_sel];
          others = 1'b0;
          for (int i = 0; i < NUM_SRC; i++) if (i != m_sel && req[i]) others = 1'b1;
          if (!trig) begin
            m_dwell = auto_en ? m_dwell + 1 : 0;
            show = 1'b1;
          end else if (others) begin
            m_phase = 2; m_blank_left = BLANK; m_dwell = 0;
          end else if (req[m_sel]) begin
            m_dwell = 0; show = 1'b1;
          end else begin
            m_phase = 0; m_dwell = 0;
          end
        end
        default: begin
          m_blank_left--;
          if (m_blank_left == 0) begin
            nsel = first_from(req, (m_sel + 1) % NUM_SRC);
            if (nsel >= 0) begin
              e.pulse = (nsel != m_sel);
              m_sel = nsel; m_phase = 1; m_dwell = 0;
            end else begin
              m_phase = 0;
            end
          end
        end
      endcase
      if (show) begin
        e.ledr = src_frame[FW*m_sel +: 10];
        e.hex  = src_frame[FW*m_sel + 10 +: 48];
      end
    end
    e.sel = m_sel;
    exp_q.push_back(e);
    if (e.pulse) sw_q.push_back(m_sel);
  end

  // Monitor: one expected entry per cycle, plus a switch event per strobe.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL display: no expected entry queued at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (LEDR !== e.ledr || {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== e.hex ||
          sel !== SEL_W'(e.sel) || switch_pulse !== e.pulse) begin
        n_bad++;
        $display("FAIL display @%0t: got ledr=%h hex=%h sel=%0d pulse=%b, want ledr=%h hex=%h sel=%0d pulse=%b",
                 $time, LEDR, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, sel, switch_pulse,
                 e.ledr, e.hex, e.sel, e.pulse);
      end
    end
    if (switch_pulse === 1'b1) begin
      n_vec++;
      if (sw_q.size() == 0) begin
        n_bad++;
        $display("FAIL switch @%0t: got strobe to sel=%0d, want no switch", $time, sel);
      end else begin
        s = sw_q.pop_front();
        if (sel !== SEL_W'(s)) begin
          n_bad++;
          $display("FAIL switch @%0t: got sel=%0d, want sel=%0d", $time, sel, s);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_frames();
    logic [63:0] r;
    logic [FW-1:0] f;
    for (int i = 0; i < NUM_SRC; i++) begin
      r = {$urandom(), $urandom()};
      f = '0;
      f[display_pkg::LEDR_LSB +: 10] = (i == 0) ? 10'h155 : 10'h2AA;
      f[display_pkg::HEX0_LSB +: 48] = r[47:0];
      src_frame[FW*i +: FW] = f;
    end
  endtask

  task automatic press();
    key_next_n = 1'b0;
    step(9);
    key_next_n = 1'b1;
    step(9);
  endtask

  // Negative arguments are wildcards; an expired bound counts as a miscompare.
  task automatic wait_model(input int ph, input int dw, input int bl, input int sl,
                            input int limit, input string name);
    int c;
    c = 0;
    while (!(m_phase == ph && (dw < 0 || m_dwell == dw) &&
             (bl < 0 || m_blank_left == bl) && (sl < 0 || m_sel == sl)) && c < limit) begin
      step(1);
      c++;
    end
    n_vec++;
    if (c >= limit) begin
      n_bad++;
      $display("FAIL wait_%s: got no match after %0d cycles, want phase=%0d", name, limit, ph);
    end
  endtask

  initial begin
    int key_left;
    reset_n = 1'b0; src_req = '0; key_next_n = 1'b1; auto_en = 1'b0;
    set_frames();
    step(3);
    reset_n = 1'b1;
    src_req = 2'b11;
    step(4);
    // Short glitch, then a real press.
    key_next_n = 1'b0; step(2); key_next_n = 1'b1; step(10);
    key_next_n = 1'b0; step(8); key_next_n = 1'b1; step(15);
    // Auto-rotate, then a press landing on the dwell expiry.
    auto_en = 1'b1;
    step(45);
    wait_model(1, DWELL - 8, -1, -1, 80, "dwell_align");
    press();
    step(20);
    auto_en = 1'b0;
    // Request drop and single requester.
    wait_model(1, -1, -1, -1, 40, "show");
    if (m_sel != 1) begin
      press();
      wait_model(1, -1, -1, 1, 40, "show_sel1");
    end
    src_req = 2'b01; step(8);
    src_req = 2'b00; step(4);
    src_req = 2'b10; step(4);
    press(); step(4);
    // Reset in the second blanking cycle.
    src_req = 2'b11;
    key_next_n = 1'b0;
    wait_model(2, -1, BLANK - 1, -1, 40, "blank2");
    reset_n = 1'b0; key_next_n = 1'b1;
    step(1);
    reset_n = 1'b1;
    step(6);
    // Randomized traffic.
    key_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) src_req = NUM_SRC'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
      if (key_left > 0) begin
        key_left--;
        if (key_left == 0) key_next_n = 1'b1;
      end else if ($urandom_range(0, 24) == 0) begin
        key_next_n = 1'b0;
        key_left = int'($urandom_range(1, 12));
      end
      reset_n = ($urandom_range(0, 799) != 0);
      set_frames();
      step(1);
    end
    reset_n = 1'b1;
    step(2);
    @(negedge clk);
    #1;
    n_vec++;
    if (sw_q.size() != 0) begin
      n_bad++;
      $display("FAIL switch_drain: got %0d unobserved switches, want 0", sw_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
